// File: rtl/operand_recover_pkg.sv
// operand_recover shared types and helpers.
// Imported by the interface, digit slice and top.
package operand_recover_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } or_state_t;

    function automatic int ndig(input int swidth, input int digit);
        return (swidth + digit - 1) / digit;
    endfunction

endpackage

// File: rtl/operand_recover_if.sv
// Request/response handshake bundle for operand_recover.
// master drives requests, slave is the recover block.
interface operand_recover_if #(
    parameter int WIDTH  = 8,
    parameter int SWIDTH = WIDTH + 1
);
    logic              in_valid;
    logic              in_ready;
    logic [SWIDTH-1:0] sm;
    logic [WIDTH-1:0]  x;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  y;
    logic              y_err;
    logic              y_zero;

    modport master (
        output in_valid, sm, x, cin, out_ready,
        input  in_ready, out_valid, y, y_err, y_zero
    );

    modport slave (
        input  in_valid, sm, x, cin, out_ready,
        output in_ready, out_valid, y, y_err, y_zero
    );
endinterface

// File: rtl/operand_recover_digit.sv
// One DIGIT-bit subtract slice: d = a - b - bin.
// bout is set when the slice result went negative.
module operand_recover_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);
    logic [DIGIT:0] diff;

    assign diff = {1'b0, a} - {1'b0, b} - (DIGIT+1)'(bin);
    assign d    = diff[DIGIT-1:0];
    assign bout = diff[DIGIT];
endmodule

// File: rtl/operand_recover.sv
// Digit-serial recovery of y = sm - x - cin, with
// range flag, over a valid/ready request/response pair.
module operand_recover
    import operand_recover_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SWIDTH = WIDTH + 1,
    parameter int DIGIT  = 1
) (
    input logic           clk,
    input logic           rst_n,
    operand_recover_if.slave bus
);
    localparam int NDIG = ndig(SWIDTH, DIGIT);
    localparam int PW   = NDIG * DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    or_state_t         state_q;
    or_state_t         state_d;
    logic [PW-1:0]     sm_sr;
    logic [PW-1:0]     x_sr;
    logic [PW-1:0]     res_sr;
    logic [PW-1:0]     res_nx;
    logic              borrow_q;
    logic              bout;
    logic [DIGIT-1:0]  dgt;
    logic [CW-1:0]     cnt_q;
    logic              last;
    logic [WIDTH-1:0]  y_q;
    logic              y_err_q;
    logic              y_zero_q;
    logic              accept;
    logic              release_out;

    operand_recover_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (sm_sr[DIGIT-1:0]),
        .b    (x_sr[DIGIT-1:0]),
        .bin  (borrow_q),
        .d    (dgt),
        .bout (bout)
    );

    // New digit enters at the MSB end; after NDIG
    // steps the full difference is right-aligned.
    generate
        if (NDIG == 1) begin : g_one
            assign res_nx = dgt;
        end else begin : g_many
            assign res_nx = {dgt, res_sr[PW-1:DIGIT]};
        end
    endgenerate

    assign last        = (cnt_q == CW'(NDIG - 1));
    assign accept      = (state_q == IDLE) && bus.in_valid;
    assign release_out = (state_q == DONE) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) state_d = BUSY;
            BUSY: if (last)         state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sm_sr    <= '0;
            x_sr     <= '0;
            res_sr   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            sm_sr    <= PW'(bus.sm);
            x_sr     <= PW'(bus.x);
            res_sr   <= '0;
            borrow_q <= bus.cin;
            cnt_q    <= '0;
        end else if (state_q == BUSY) begin
            sm_sr    <= sm_sr >> DIGIT;
            x_sr     <= x_sr >> DIGIT;
            res_sr   <= res_nx;
            borrow_q <= bout;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q      <= '0;
            y_err_q  <= 1'b0;
            y_zero_q <= 1'b0;
        end else if (state_q == BUSY && last) begin
            y_q      <= res_nx[WIDTH-1:0];
            y_err_q  <= bout | (|res_nx[PW-1:WIDTH]);
            y_zero_q <= (res_nx[WIDTH-1:0] == '0);
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.y         = y_q;
    assign bus.y_err     = y_err_q;
    assign bus.y_zero    = y_zero_q;

    logic unused_release;
    assign unused_release = release_out;
endmodule

// File: tb/tb_operand_recover.sv
// Self-checking bench: directed cases and random
// sweeps for DIGIT=1 and DIGIT=2 instances.
module tb_operand_recover;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    operand_recover_if #(.WIDTH(8), .SWIDTH(9)) b1 ();
    operand_recover_if #(.WIDTH(8), .SWIDTH(9)) b2 ();

    operand_recover #(.WIDTH(8), .SWIDTH(9), .DIGIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    operand_recover #(.WIDTH(8), .SWIDTH(9), .DIGIT(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed integer difference and its range.
    function automatic void model(input int s, input int a, input int c,
                                  output int ey, output int ee,
                                  output int ez);
        int diff;
        diff = s - a - c;
        ey = diff & 255;
        ee = (diff < 0 || diff >= 256) ? 1 : 0;
        ez = (ey == 0) ? 1 : 0;
    endfunction

    task automatic req1(input string tag, input int s, input int a,
                        input int c, input int hold);
        int ey, ee, ez, lat;
        logic [7:0] ys;
        logic es, zs;
        model(s, a, c, ey, ee, ez);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(b1.in_ready), 32'd1);
        b1.sm = 9'(s);
        b1.x = 8'(a);
        b1.cin = c[0];
        b1.in_valid = 1'b1;
        @(posedge clk);
        #1 b1.in_valid = 1'b0;
        lat = 0;
        while (!b1.out_valid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd9);
        chk({tag, "_y"}, 32'(b1.y), 32'(ey));
        chk({tag, "_err"}, 32'(b1.y_err), 32'(ee));
        chk({tag, "_zero"}, 32'(b1.y_zero), 32'(ez));
        ys = b1.y;
        es = b1.y_err;
        zs = b1.y_zero;
        for (int i = 0; i < hold; i++) begin
            b1.in_valid = ~b1.in_valid;
            b1.sm = 9'($urandom);
            @(posedge clk);
            #1;
            chk({tag, "_hold_v"}, 32'(b1.out_valid), 32'd1);
            chk({tag, "_hold_rdy"}, 32'(b1.in_ready), 32'd0);
            chk({tag, "_hold_y"}, {21'd0, zs, es, b1.y == ys ? 8'd1 : 8'd0},
                {21'd0, b1.y_zero, b1.y_err, 8'd1});
        end
        b1.in_valid = 1'b0;
        @(negedge clk);
        b1.out_ready = 1'b1;
        @(posedge clk);
        #1 b1.out_ready = 1'b0;
        chk({tag, "_post_v"}, 32'(b1.out_valid), 32'd0);
        chk({tag, "_post_rdy"}, 32'(b1.in_ready), 32'd1);
    endtask

    initial begin
        int ey, ee, ez, lat, xa, ya, ca, sa;
        b1.in_valid = 0; b1.sm = 0; b1.x = 0; b1.cin = 0;
        b1.out_ready = 0;
        b2.in_valid = 0; b2.sm = 0; b2.x = 0; b2.cin = 0;
        b2.out_ready = 0;
        #1;
        chk("rst_in_ready", 32'(b1.in_ready), 32'd1);
        chk("rst_out_valid", 32'(b1.out_valid), 32'd0);
        chk("rst_outs", {22'd0, b1.y_err, b1.y_zero, b1.y}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        req1("normal", 'h0FF, 'h7F, 1, 0);
        req1("zero", 'h001, 'h00, 1, 0);
        req1("neg", 'h005, 'h06, 0, 0);
        req1("ovf", 'h1FF, 'h00, 0, 5);

        // Abort a transaction partway through BUSY.
        @(negedge clk);
        b1.sm = 9'h123; b1.x = 8'h11; b1.cin = 0;
        b1.in_valid = 1'b1;
        @(posedge clk);
        #1 b1.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v", 32'(b1.out_valid), 32'd0);
        chk("mid_rst_outs", {22'd0, b1.y_err, b1.y_zero, b1.y}, 32'd0);
        chk("mid_rst_rdy", 32'(b1.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        req1("after_rst", 'h100, 'h01, 0, 0);

        for (int i = 0; i < 40; i++)
            req1("rand1", int'($urandom_range(511)),
                 int'($urandom_range(255)), int'($urandom_range(1)), 0);

        b2.out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            xa = int'($urandom_range(255));
            ya = int'($urandom_range(255));
            ca = int'($urandom_range(1));
            sa = xa + ya + ca;
            model(sa, xa, ca, ey, ee, ez);
            @(negedge clk);
            chk("d2_rdy", 32'(b2.in_ready), 32'd1);
            b2.sm = 9'(sa); b2.x = 8'(xa); b2.cin = ca[0];
            b2.in_valid = 1'b1;
            @(posedge clk);
            #1 b2.in_valid = 1'b0;
            lat = 0;
            while (!b2.out_valid && lat < 50) begin
                @(posedge clk);
                #1 lat++;
            end
            chk("d2_lat", 32'(lat), 32'd5);
            chk("d2_y", 32'(b2.y), 32'(ya));
            chk("d2_err", 32'(b2.y_err), 32'(ee));
            chk("d2_zero", 32'(b2.y_zero), 32'(ez));
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
